// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the mux scan controller.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    localparam int DEF_NUM_CH = 8;
    localparam int DEF_SETTLE = 1;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Finds the lowest set mask bit strictly above cur, or the lowest set bit
// overall when from_start is high.
module mux_scan_next_ch #(
    parameter int NUM_CH = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              from_start,
    output logic [SEL_W-1:0]  next,
    output logic              found
);

    always_comb begin
        next  = '0;
        found = 1'b0;
        // Descending walk so the lowest qualifying index is the last writer.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(cur)))) begin
                next  = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the 8:1 mux select over the enabled channels, samples each after a
// settle delay, and hands the assembled word out over valid/ready.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; sel holds its last value
// S_SETTLE | counting down after a sel change; sample when count hits 0
// S_HOLD   | word/word_valid stable until the consumer accepts
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = $clog2(NUM_CH),
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [SEL_W-1:0]  sel,
    input  logic              mux_in,
    output logic [NUM_CH-1:0] word,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic [NUM_CH-1:0]  shadow_q, shadow_d, shadow_smp;
    logic [NUM_CH-1:0]  word_q, word_d;
    logic               valid_q, valid_d;
    logic [SEL_W-1:0]   sel_q, sel_d;

    logic [NUM_CH-1:0]  search_mask;
    logic               from_start;
    logic [SEL_W-1:0]   nxt_ch;
    logic               nxt_found;

    // In IDLE the search runs on the live mask so the first channel is known
    // on the accepting edge.
    assign from_start  = (state_q == S_IDLE);
    assign search_mask = from_start ? ch_mask : mask_q;

    mux_scan_next_ch #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_next_ch (
        .mask       (search_mask),
        .cur        (sel_q),
        .from_start (from_start),
        .next       (nxt_ch),
        .found      (nxt_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mask_q   <= '0;
            shadow_q <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            sel_q    <= sel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        shadow_d   = shadow_q;
        word_d     = word_q;
        valid_d    = valid_q;
        sel_d      = sel_q;
        shadow_smp = shadow_q;
        shadow_smp[sel_q] = mux_in;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (|ch_mask) begin
                        mask_d   = ch_mask;
                        shadow_d = '0;
                        sel_d    = nxt_ch;
                        cnt_d    = CNT_W'(SETTLE);
                        state_d  = S_SETTLE;
                    end else begin
                        word_d  = '0;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shadow_d = shadow_smp;
                    if (nxt_found) begin
                        sel_d = nxt_ch;
                        cnt_d = CNT_W'(SETTLE);
                    end else begin
                        word_d  = shadow_smp;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (valid_q && word_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sel        = sel_q;
    assign word       = word_q;
    assign word_valid = valid_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: instance 0 has SETTLE=0, instance 1
// has SETTLE=1, each driven through its own 8:1 mux model.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       fault;

    logic       start_a [2];
    logic [7:0] mask_a  [2];
    logic [2:0] sel_a   [2];
    logic       mux_in_a[2];
    logic [7:0] word_a  [2];
    logic       valid_a [2];
    logic       ready_a [2];
    logic       busy_a  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_mux
        assign mux_in_a[g] = (fault && sel_a[g] >= 3'd4) ? 1'b0 : data[sel_a[g]];
    end

    mux_scan_sequencer #(.NUM_CH(8), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start_a[0]), .ch_mask(mask_a[0]),
        .sel(sel_a[0]), .mux_in(mux_in_a[0]), .word(word_a[0]),
        .word_valid(valid_a[0]), .word_ready(ready_a[0]), .busy(busy_a[0])
    );

    mux_scan_sequencer #(.NUM_CH(8), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_a[1]), .ch_mask(mask_a[1]),
        .sel(sel_a[1]), .mux_in(mux_in_a[1]), .word(word_a[1]),
        .word_valid(valid_a[1]), .word_ready(ready_a[1]), .busy(busy_a[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         d;      // instance index == its SETTLE value
        logic [7:0] mask;
        logic [7:0] data;
        bit         fault;
        logic [7:0] exp;
    } vec_t;

    // Starts a scan, then walks edge by edge: sel must follow the enabled
    // channels in ascending order, each held SETTLE+1 cycles, and word_valid
    // must appear after edge E0 + k*(SETTLE+1).
    task automatic run_scan(input int d, input logic [7:0] mask, input logic [7:0] exp, input string name);
        int en[8];
        int k = 0;
        int lat;
        for (int i = 0; i < 8; i++) if (mask[i]) begin en[k] = i; k++; end
        lat = k * (d + 1);
        @(negedge clk);
        ready_a[d] = 1'b1;
        mask_a[d]  = mask;
        start_a[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a[d] = 1'b0;
        mask_a[d]  = ~mask;     // must not disturb the latched scan
        for (int j = 0; j <= lat; j++) begin
            if (j < lat) begin
                chk({name, " valid_low"}, valid_a[d], 1'b0);
                chk({name, " sel"}, sel_a[d], en[j / (d + 1)]);
                chk({name, " busy"}, busy_a[d], 1'b1);
                @(posedge clk);
                @(negedge clk);
            end else begin
                chk({name, " valid_high"}, valid_a[d], 1'b1);
                chk({name, " word"}, word_a[d], exp);
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk({name, " valid_drop"}, valid_a[d], 1'b0);
        chk({name, " idle"}, busy_a[d], 1'b0);
        mask_a[d] = 8'h00;
    endtask

    vec_t vecs[7];

    initial begin
        bit seen;

        vecs[0] = '{d: 1, mask: 8'hFF, data: 8'b10101100, fault: 1'b0, exp: 8'b10101100};
        vecs[1] = '{d: 1, mask: 8'hFF, data: 8'b10101100, fault: 1'b1, exp: 8'b00001100};
        vecs[2] = '{d: 1, mask: 8'b10000001, data: 8'b10101100, fault: 1'b0, exp: 8'b10000000};
        vecs[3] = '{d: 1, mask: 8'h00, data: 8'b10101100, fault: 1'b0, exp: 8'h00};
        vecs[4] = '{d: 0, mask: 8'hFF, data: 8'b10101100, fault: 1'b0, exp: 8'b10101100};
        vecs[5] = '{d: 1, mask: 8'b01010010, data: 8'hFF, fault: 1'b0, exp: 8'b01010010};
        vecs[6] = '{d: 0, mask: 8'b00100100, data: 8'b00100000, fault: 1'b0, exp: 8'b00100000};

        rst = 1'b1;
        data = 8'h00;
        fault = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_a[i] = 1'b0;
            mask_a[i]  = 8'h00;
            ready_a[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset sel", sel_a[1], 3'd0);
        chk("reset word", word_a[1], 8'h00);
        chk("reset valid", valid_a[1], 1'b0);
        chk("reset busy", busy_a[1], 1'b0);

        for (int v = 0; v < 7; v++) begin
            data  = vecs[v].data;
            fault = vecs[v].fault;
            run_scan(vecs[v].d, vecs[v].mask, vecs[v].exp, $sformatf("vec%0d", v));
        end
        fault = 1'b0;
        data  = 8'b10101100;

        // Backpressure: mask {1,2} gives word 8'h04 after edge E0+4.
        @(negedge clk);
        ready_a[1] = 1'b0;
        mask_a[1]  = 8'b00000110;
        start_a[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a[1] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp valid_rise", valid_a[1], 1'b1);
        chk("bp word", word_a[1], 8'h04);
        for (int c = 0; c < 5; c++) begin
            start_a[1] = (c == 2);
            mask_a[1]  = 8'hFF;
            @(posedge clk);
            @(negedge clk);
            chk("bp valid_hold", valid_a[1], 1'b1);
            chk("bp word_hold", word_a[1], 8'h04);
            chk("bp busy_hold", busy_a[1], 1'b1);
        end
        ready_a[1] = 1'b1;
        start_a[1] = 1'b1;      // ignored on the handshake edge
        @(posedge clk);
        @(negedge clk);
        start_a[1] = 1'b0;
        chk("bp valid_drop", valid_a[1], 1'b0);
        chk("bp busy_drop", busy_a[1], 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("bp no_restart", busy_a[1], 1'b0);

        // Reset at the 3rd sample edge (E0+6) of a full-mask scan.
        @(negedge clk);
        mask_a[1]  = 8'hFF;
        start_a[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a[1] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst pre_sel", sel_a[1], 3'd2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst sel", sel_a[1], 3'd0);
        chk("rst word", word_a[1], 8'h00);
        chk("rst valid", valid_a[1], 1'b0);
        chk("rst busy", busy_a[1], 1'b0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (valid_a[1] || busy_a[1]) seen = 1'b1;
        end
        chk("rst no_valid_after_abort", seen, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
